// File: rtl/mips_pkg.sv
// Shared encodings and constants for the MIPS pipeline stages.
// Includes the stall FSM states and the bubble control word.
package mips_pkg;

    localparam int ALUOP_W = 3;

    typedef enum logic [1:0] {
        STALL_RUN  = 2'b00,
        STALL_LU   = 2'b01,
        STALL_HOLD = 2'b10
    } stall_e;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_exe_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination
// is read by the instruction in ID. $0 never creates a hazard.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             uses_rt,
    output logic             load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = (ex_rt == id_rs);
    assign rt_hit   = uses_rt && (ex_rt == id_rt);
    assign load_use = mem_read && (ex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with load-use stall, branch flush,
// external hold, debug stall-state FSM and saturating stall counter.
module id_exe_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IDRegWrite,
    input  logic              IDMemRead,
    input  logic              IDMemWrite,
    input  logic              IDMemToReg,
    input  logic              IDALUSrc,
    input  logic              IDRegDst,
    input  logic [2:0]        IDALUOp,
    input  logic [REG_W-1:0]  IDRs,
    input  logic [REG_W-1:0]  IDRt,
    input  logic [REG_W-1:0]  IDRd,
    input  logic              IDUsesRt,
    input  logic [DATA_W-1:0] IDReadData1,
    input  logic [DATA_W-1:0] IDReadData2,
    input  logic [DATA_W-1:0] IDImm,
    input  logic              flush,
    input  logic              extStall,
    output logic              EXERegWrite,
    output logic              EXEMemRead,
    output logic              EXEMemWrite,
    output logic              EXEMemToReg,
    output logic              EXEALUSrc,
    output logic              EXERegDst,
    output logic [2:0]        EXEALUOp,
    output logic [REG_W-1:0]  EXERs,
    output logic [REG_W-1:0]  EXERt,
    output logic [REG_W-1:0]  EXERd,
    output logic [DATA_W-1:0] EXEReadData1,
    output logic [DATA_W-1:0] EXEReadData2,
    output logic [DATA_W-1:0] EXEImm,
    output logic              pcWrite,
    output logic              IFIDWrite,
    output logic [1:0]        stallState,
    output logic [CNT_W-1:0]  stallCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t             ex_ctrl;
    ctrl_t             id_ctrl;
    stall_e            state;
    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use;

    assign id_ctrl = '{
        reg_write:  IDRegWrite,
        mem_read:   IDMemRead,
        mem_write:  IDMemWrite,
        mem_to_reg: IDMemToReg,
        alu_src:    IDALUSrc,
        reg_dst:    IDRegDst,
        alu_op:     IDALUOp
    };

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .mem_read (ex_ctrl.mem_read),
        .ex_rt    (EXERt),
        .id_rs    (IDRs),
        .id_rt    (IDRt),
        .uses_rt  (IDUsesRt),
        .load_use (load_use)
    );

    // A flush always lets the front end advance, even while held.
    assign pcWrite   = flush || (!extStall && !load_use);
    assign IFIDWrite = pcWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_ctrl      <= CTRL_BUBBLE;
            EXERs        <= '0;
            EXERt        <= '0;
            EXERd        <= '0;
            EXEReadData1 <= '0;
            EXEReadData2 <= '0;
            EXEImm       <= '0;
            state        <= STALL_RUN;
        end else if (flush || (!extStall && load_use)) begin
            ex_ctrl      <= CTRL_BUBBLE;
            EXERs        <= '0;
            EXERt        <= '0;
            EXERd        <= '0;
            EXEReadData1 <= '0;
            EXEReadData2 <= '0;
            EXEImm       <= '0;
            state        <= flush ? STALL_RUN : STALL_LU;
        end else if (extStall) begin
            state        <= STALL_HOLD;
        end else begin
            ex_ctrl      <= id_ctrl;
            EXERs        <= IDRs;
            EXERt        <= IDRt;
            EXERd        <= IDRd;
            EXEReadData1 <= IDReadData1;
            EXEReadData2 <= IDReadData2;
            EXEImm       <= IDImm;
            state        <= STALL_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pcWrite && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign EXERegWrite = ex_ctrl.reg_write;
    assign EXEMemRead  = ex_ctrl.mem_read;
    assign EXEMemWrite = ex_ctrl.mem_write;
    assign EXEMemToReg = ex_ctrl.mem_to_reg;
    assign EXEALUSrc   = ex_ctrl.alu_src;
    assign EXERegDst   = ex_ctrl.reg_dst;
    assign EXEALUOp    = ex_ctrl.alu_op;
    assign stallState  = state;
    assign stallCount  = stall_cnt;

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage: vector table plus reset,
// hold and counter-saturation sequences.
module tb_id_exe_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        IDRegWrite, IDMemRead, IDMemWrite, IDMemToReg;
    logic        IDALUSrc, IDRegDst, IDUsesRt, flush, extStall;
    logic [2:0]  IDALUOp;
    logic [4:0]  IDRs, IDRt, IDRd;
    logic [31:0] IDReadData1, IDReadData2, IDImm;

    logic        EXERegWrite, EXEMemRead, EXEMemWrite, EXEMemToReg;
    logic        EXEALUSrc, EXERegDst, pcWrite, IFIDWrite;
    logic [2:0]  EXEALUOp;
    logic [4:0]  EXERs, EXERt, EXERd;
    logic [31:0] EXEReadData1, EXEReadData2, EXEImm;
    logic [1:0]  stallState;
    logic [15:0] stallCount;

    logic        s_rw, s_mr, s_mw, s_mtr, s_as, s_rd, s_pc, s_ifid;
    logic [2:0]  s_op;
    logic [4:0]  s_rs, s_rt, s_rdn;
    logic [31:0] s_d1, s_d2, s_imm;
    logic [1:0]  s_st;
    logic [3:0]  s_cnt;

    id_exe_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .IDRegWrite(IDRegWrite), .IDMemRead(IDMemRead),
        .IDMemWrite(IDMemWrite), .IDMemToReg(IDMemToReg),
        .IDALUSrc(IDALUSrc), .IDRegDst(IDRegDst), .IDALUOp(IDALUOp),
        .IDRs(IDRs), .IDRt(IDRt), .IDRd(IDRd), .IDUsesRt(IDUsesRt),
        .IDReadData1(IDReadData1), .IDReadData2(IDReadData2),
        .IDImm(IDImm), .flush(flush), .extStall(extStall),
        .EXERegWrite(EXERegWrite), .EXEMemRead(EXEMemRead),
        .EXEMemWrite(EXEMemWrite), .EXEMemToReg(EXEMemToReg),
        .EXEALUSrc(EXEALUSrc), .EXERegDst(EXERegDst),
        .EXEALUOp(EXEALUOp), .EXERs(EXERs), .EXERt(EXERt),
        .EXERd(EXERd), .EXEReadData1(EXEReadData1),
        .EXEReadData2(EXEReadData2), .EXEImm(EXEImm),
        .pcWrite(pcWrite), .IFIDWrite(IFIDWrite),
        .stallState(stallState), .stallCount(stallCount)
    );

    id_exe_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .IDRegWrite(IDRegWrite), .IDMemRead(IDMemRead),
        .IDMemWrite(IDMemWrite), .IDMemToReg(IDMemToReg),
        .IDALUSrc(IDALUSrc), .IDRegDst(IDRegDst), .IDALUOp(IDALUOp),
        .IDRs(IDRs), .IDRt(IDRt), .IDRd(IDRd), .IDUsesRt(IDUsesRt),
        .IDReadData1(IDReadData1), .IDReadData2(IDReadData2),
        .IDImm(IDImm), .flush(flush), .extStall(extStall),
        .EXERegWrite(s_rw), .EXEMemRead(s_mr), .EXEMemWrite(s_mw),
        .EXEMemToReg(s_mtr), .EXEALUSrc(s_as), .EXERegDst(s_rd),
        .EXEALUOp(s_op), .EXERs(s_rs), .EXERt(s_rt), .EXERd(s_rdn),
        .EXEReadData1(s_d1), .EXEReadData2(s_d2), .EXEImm(s_imm),
        .pcWrite(s_pc), .IFIDWrite(s_ifid),
        .stallState(s_st), .stallCount(s_cnt)
    );

    typedef struct {
        logic        mr;
        logic [4:0]  rs, rt, rd;
        logic        ur;
        logic [31:0] d1;
        logic        fl, ex;
        logic        pc;
        logic        emr;
        logic [4:0]  ers, ert, erd;
        logic [31:0] ed1;
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[20];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        logic mr, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
        logic ur, logic [31:0] d1, logic fl, logic ex, logic pc,
        logic emr, logic [4:0] ers, logic [4:0] ert, logic [4:0] erd,
        logic [31:0] ed1, logic [1:0] st, logic [15:0] cnt);
        vec_t v;
        v.mr = mr; v.rs = rs; v.rt = rt; v.rd = rd; v.ur = ur;
        v.d1 = d1; v.fl = fl; v.ex = ex; v.pc = pc; v.emr = emr;
        v.ers = ers; v.ert = ert; v.erd = erd; v.ed1 = ed1;
        v.st = st; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic mr, logic [4:0] rs, logic [4:0] rt,
                         logic [4:0] rd, logic ur, logic [31:0] d1,
                         logic fl, logic ex);
        IDRegWrite  = 1'b1;
        IDMemRead   = mr;
        IDMemWrite  = 1'b0;
        IDMemToReg  = mr;
        IDALUSrc    = mr;
        IDRegDst    = ~mr;
        IDALUOp     = rd[2:0];
        IDRs        = rs;
        IDRt        = rt;
        IDRd        = rd;
        IDUsesRt    = ur;
        IDReadData1 = d1;
        IDReadData2 = ~d1;
        IDImm       = d1 + 32'd1;
        flush       = fl;
        extStall    = ex;
    endtask

    task automatic chk_exe(string tag, logic emr, logic [4:0] ers,
                           logic [4:0] ert, logic [4:0] erd,
                           logic [31:0] ed1);
        logic live;
        logic [2:0] op;
        live = (ed1 != 32'd0);
        op = erd[2:0];
        chk({tag, " MemRead"}, 32'(EXEMemRead), 32'(emr));
        chk({tag, " MemToReg"}, 32'(EXEMemToReg), 32'(emr));
        chk({tag, " RegWrite"}, 32'(EXERegWrite), 32'(live));
        chk({tag, " RegDst"}, 32'(EXERegDst), 32'(live && !emr));
        chk({tag, " ALUOp"}, 32'(EXEALUOp), 32'(op));
        chk({tag, " Rs"}, 32'(EXERs), 32'(ers));
        chk({tag, " Rt"}, 32'(EXERt), 32'(ert));
        chk({tag, " Rd"}, 32'(EXERd), 32'(erd));
        chk({tag, " RD1"}, EXEReadData1, ed1);
        chk({tag, " RD2"}, EXEReadData2, live ? ~ed1 : 32'd0);
        chk({tag, " Imm"}, EXEImm, live ? ed1 + 32'd1 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // mr rs rt rd ur d1 fl ex | pc emr ers ert erd ed1 st cnt
        tbl[0]  = mk(1, 1, 5, 0, 0, 32'h11, 0, 0, 1, 1, 1, 5, 0, 32'h11, 0, 0);
        tbl[1]  = mk(0, 5, 2, 3, 1, 32'h22, 0, 0, 0, 0, 0, 0, 0, 32'h00, 1, 1);
        tbl[2]  = mk(0, 5, 2, 3, 1, 32'h22, 0, 0, 1, 0, 5, 2, 3, 32'h22, 0, 1);
        tbl[3]  = mk(1, 2, 7, 0, 0, 32'h33, 0, 0, 1, 1, 2, 7, 0, 32'h33, 0, 1);
        tbl[4]  = mk(0, 3, 7, 4, 0, 32'h44, 0, 0, 1, 0, 3, 7, 4, 32'h44, 0, 1);
        tbl[5]  = mk(1, 0, 7, 0, 0, 32'h55, 0, 0, 1, 1, 0, 7, 0, 32'h55, 0, 1);
        tbl[6]  = mk(0, 1, 7, 6, 1, 32'h66, 0, 0, 0, 0, 0, 0, 0, 32'h00, 1, 2);
        tbl[7]  = mk(0, 1, 7, 6, 1, 32'h66, 0, 0, 1, 0, 1, 7, 6, 32'h66, 0, 2);
        tbl[8]  = mk(1, 4, 0, 0, 0, 32'h77, 0, 0, 1, 1, 4, 0, 0, 32'h77, 0, 2);
        tbl[9]  = mk(0, 0, 0, 2, 1, 32'h88, 0, 0, 1, 0, 0, 0, 2, 32'h88, 0, 2);
        tbl[10] = mk(1, 1, 8, 0, 0, 32'h99, 0, 0, 1, 1, 1, 8, 0, 32'h99, 0, 2);
        tbl[11] = mk(1, 8, 9, 0, 0, 32'hAA, 0, 0, 0, 0, 0, 0, 0, 32'h00, 1, 3);
        tbl[12] = mk(1, 8, 9, 0, 0, 32'hAA, 0, 0, 1, 1, 8, 9, 0, 32'hAA, 0, 3);
        tbl[13] = mk(0, 9, 1, 5, 1, 32'hBB, 0, 0, 0, 0, 0, 0, 0, 32'h00, 1, 4);
        tbl[14] = mk(0, 9, 1, 5, 1, 32'hBB, 0, 0, 1, 0, 9, 1, 5, 32'hBB, 0, 4);
        tbl[15] = mk(0, 2, 3, 4, 1, 32'hCC, 0, 1, 0, 0, 9, 1, 5, 32'hBB, 2, 5);
        tbl[16] = mk(0, 2, 3, 4, 1, 32'hCC, 0, 1, 0, 0, 9, 1, 5, 32'hBB, 2, 6);
        tbl[17] = mk(0, 2, 3, 4, 1, 32'hCC, 0, 1, 0, 0, 9, 1, 5, 32'hBB, 2, 7);
        tbl[18] = mk(0, 2, 3, 4, 1, 32'hCC, 1, 1, 1, 0, 0, 0, 0, 32'h00, 0, 7);
        tbl[19] = mk(0, 2, 3, 4, 1, 32'hCC, 0, 0, 1, 0, 2, 3, 4, 32'hCC, 0, 7);

        drive(0, 0, 0, 0, 0, 32'h1, 0, 0);
        #2;
        chk_exe("por", 0, 0, 0, 0, 0);
        chk("por state", 32'(stallState), 32'd0);
        chk("por count", 32'(stallCount), 32'd0);
        chk("por pcWrite", 32'(pcWrite), 32'd1);
        #10;
        rst = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(tbl[i].mr, tbl[i].rs, tbl[i].rt, tbl[i].rd,
                  tbl[i].ur, tbl[i].d1, tbl[i].fl, tbl[i].ex);
            #1;
            chk({tag, " pcWrite"}, 32'(pcWrite), 32'(tbl[i].pc));
            chk({tag, " IFIDWrite"}, 32'(IFIDWrite), 32'(tbl[i].pc));
            tick();
            chk_exe(tag, tbl[i].emr, tbl[i].ers, tbl[i].ert,
                    tbl[i].erd, tbl[i].ed1);
            chk({tag, " state"}, 32'(stallState), 32'(tbl[i].st));
            chk({tag, " count"}, 32'(stallCount), 32'(tbl[i].cnt));
            chk({tag, " count4"}, 32'(s_cnt), 32'(tbl[i].cnt));
        end

        // Long hold: 16-bit counter keeps counting, 4-bit one pins at 15.
        drive(0, 3, 4, 5, 1, 32'hDD, 0, 1);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("hold%0d pcWrite", i), 32'(pcWrite), 32'd0);
            tick();
        end
        chk("hold state", 32'(stallState), 32'd2);
        chk("hold count", 32'(stallCount), 32'd27);
        chk("sat count", 32'(s_cnt), 32'd15);
        chk_exe("hold", 0, 2, 3, 4, 32'hCC);
        tick();
        chk("sat stays", 32'(s_cnt), 32'd15);
        chk("hold count2", 32'(stallCount), 32'd28);

        // Reset mid-run, away from the clock edge.
        drive(1, 6, 6, 0, 0, 32'hEE, 0, 0);
        tick();
        drive(0, 6, 1, 2, 1, 32'hF0, 0, 0);
        #1;
        chk("pre-rst pcWrite", 32'(pcWrite), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk_exe("rst", 0, 0, 0, 0, 0);
        chk("rst state", 32'(stallState), 32'd0);
        chk("rst count", 32'(stallCount), 32'd0);
        chk("rst count4", 32'(s_cnt), 32'd0);
        chk("rst pcWrite", 32'(pcWrite), 32'd1);
        #1;
        rst = 1'b1;
        tick();
        chk_exe("post-rst", 0, 6, 1, 2, 32'hF0);
        chk("post-rst state", 32'(stallState), 32'd0);
        chk("post-rst count", 32'(stallCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded control, register numbers and operands from ID, and presents them to EX and to the forwarding unit as EXERs/EXERt.
- On a load-use hazard it freezes PC and IF/ID and injects a bubble.
- Also handles branch flush and an external hold, and keeps a saturating stall counter.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register-number width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- IDRegWrite, IDMemRead, IDMemWrite, IDMemToReg, IDALUSrc, IDRegDst  in  1 each  decoded control
- IDALUOp  in  3  ALU operation
- IDRs, IDRt, IDRd  in  REG_W  register numbers
- IDUsesRt  in  1  ID instruction reads Rt as a source
- IDReadData1, IDReadData2, IDImm  in  DATA_W  operands, sign-extended immediate
- flush  in  1  branch taken in EX; squash the ID instruction
- extStall  in  1  memory busy; freeze the front end
- EXERegWrite, EXEMemRead, EXEMemWrite, EXEMemToReg, EXEALUSrc, EXERegDst  out  1 each  registered control
- EXEALUOp  out  3
- EXERs, EXERt, EXERd  out  REG_W
- EXEReadData1, EXEReadData2, EXEImm  out  DATA_W
- pcWrite, IFIDWrite  out  1  combinational enables for PC and IF/ID
- stallState  out  2  registered FSM state
- stallCount  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - all EXE* outputs are 0, so the stage holds a bubble.
  - stallState=RUN(00); stallCount=0.
  - pcWrite and IFIDWrite are still driven combinationally.
- loadUse is true when all of the following hold:
  - EXEMemRead=1
  - EXERt!=0
  - EXERt==IDRs, or (IDUsesRt=1 and EXERt==IDRt)
- Priority, evaluated every cycle, highest first: flush > extStall > loadUse > normal.
- Per-case actions:
  - flush: on the next edge load a bubble (all control and register numbers 0, data 0). pcWrite=IFIDWrite=1. State goes to RUN.
  - extStall (no flush): all ID/EX registers hold their values. pcWrite=IFIDWrite=0. State goes to HOLD(10).
  - loadUse (no flush, no extStall): load a bubble. pcWrite=IFIDWrite=0. State goes to LUSTALL(01).
  - normal: capture all ID inputs. pcWrite=IFIDWrite=1. State goes to RUN.
- FSM states: RUN=00, LUSTALL=01, HOLD=10; 11 is unused and recovers to RUN.
  - The state records the reason for the previous cycle's stall, for debug.
  - Transitions follow the priority table above; there are no other conditions.
- Latency:
  - ID to EXE outputs: 1 cycle.
  - pcWrite/IFIDWrite: same-cycle combinational from the current EXE registers and ID inputs; no registered path.
- Load-use stall length:
  - Exactly one cycle per load. The bubble clears EXEMemRead, so loadUse drops next cycle and the held instruction is re-presented.
  - Back-to-back dependent loads each stall once.
- Register 0: a load whose destination is $0 never stalls.
- stallCount:
  - increments by 1 on every edge where pcWrite=0;
  - saturates at all-ones (no wrap);
  - cleared only by reset.
- flush during extStall: flush wins, so the squashed instruction never enters EX.
- Reset mid-stall: outputs return immediately to reset values; after release the first edge captures ID normally.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package (mips_pkg):
  - STALL_RUN/STALL_LU/STALL_HOLD encodings
  - ALUOp width constant
  - bubble (all-zero) control constant
- One sub-module: hazard_detect, purely combinational. It computes loadUse from EXEMemRead, EXERt, IDRs, IDRt and IDUsesRt.
- The register bank, FSM and counter stay in id_exe_stage.

Test Plan:
- Reset: assert rst=0 mid-run -> all EXE*=0, stallState=00, stallCount=0 immediately; pcWrite=1.
- Load-use on Rs: lw $5 in EX (EXEMemRead=1, EXERt=5), ID IDRs=5 -> pcWrite=IFIDWrite=0 for 1 cycle; next EXE is a bubble; stallState=01; the following edge captures the held instruction; stallCount=1.
- Rt not used: EXERt=7 load, IDRt=7, IDUsesRt=0, IDRs=3 -> no stall, pcWrite=1, instruction captured.
- $0 destination: EXEMemRead=1, EXERt=0, IDRs=0 -> no stall.
- Hold and flush:
  - extStall=1 for 3 cycles -> EXE outputs unchanged, pcWrite=0, stallState=10, stallCount+=3.
  - then flush=1 together with extStall=1 -> bubble loaded, pcWrite=1, stallState=00.
- Saturation: CNT_W=4, hold extStall=1 for 20 cycles -> stallCount reaches 15 and stays at 15.
